mem_stage_dmem_responder: RTL
=============================

// Module: mem_stage_dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the MEM-stage control interface.
//  The MEM-stage decoder drives mem_read/mem_write; this block services each request.
//  It holds a word-addressed RAM and inserts a configurable number of wait states.
//  It drives stall so the pipeline freezes until the access completes.
// PARAMETERS
//  DEPTH_WORDS  256  RAM depth in 32-bit words; power of two, >=2
//  WAIT_STATES  2    extra BUSY cycles per access; range 0..15
// PORTS
//  clk        in   1   single clock; rising edge
//  rst        in   1   asynchronous reset, active-high
//  mem_read   in   1   load request from MEM-stage control
//  mem_write  in   1   store request from MEM-stage control
//  addr       in   32  byte address (ALU result)
//  wdata      in   32  store data
//  rdata      out  32  load data; valid only while done=1
//  done       out  1   access complete this cycle (1-cycle pulse)
//  stall      out  1   hold IF/ID/EX/MEM registers
//  fault      out  1   misaligned or conflicting request; pulses with done
// BEHAVIOUR
//  Reset (async): state=IDLE; rdata=0, done=0, stall=0, fault=0; counter=0.
//   RAM contents are not cleared.
//  req = mem_read | mem_write.
//  stall is combinational: stall = (state==IDLE & req) | (state==BUSY).
//   stall is 0 in DONE, so the pipeline advances on the edge leaving DONE.
//  States:
//   IDLE: on req, latch addr/wdata/op.
//    If WAIT_STATES==0, go to DONE; otherwise go to BUSY with cnt=WAIT_STATES-1.
//   BUSY: cnt decrements each cycle; at cnt==0, go to DONE.
//   DONE: done=1 for one cycle; go to IDLE.
//  Access commit: on the edge entering DONE, a write updates RAM[idx] and a read registers rdata.
//  Timing: a request seen in cycle 0 reaches DONE in cycle WAIT_STATES+1.
//   stall is high in cycles 0..WAIT_STATES.
//  Index: idx = latched addr[$clog2(DEPTH_WORDS)+1:2]; upper bits ignored (address aliases/wraps).
//  Faults (fault=1 in DONE, no RAM update, rdata=0):
//   - misaligned: latched addr[1:0]!=0.
//   - conflict: mem_read & mem_write both high at acceptance.
//  Latching: inputs are sampled only at acceptance in IDLE.
//   Changes to inputs during BUSY/DONE are ignored.
//  Back-to-back: after DONE the block always spends one cycle in IDLE.
//   A request present there is accepted that cycle with stall=1.
//  Reset mid-operation: BUSY/DONE abort to IDLE; a pending write is dropped (RAM unchanged).
//  Read-after-write to the same idx returns the new data; accesses are serialized.
// STRUCTURE
//  Shared package (cpu_pkg): WORD_W=32; state enum {IDLE, BUSY, DONE}; MEM_OP encodings {NONE, RD, WR}.
//  Sub-module dmem_array: single-port synchronous RAM.
//   Ports: clk, we, idx, wdata, rdata; registered read.
//   No reset on storage.
//  Top level contains the FSM, wait counter, request latch, fault logic and stall decode.
// TESTING
//  1. W=2: write 0xDEADBEEF @0x10; stall high for 3 cycles, done in cycle 3.
//     Then read @0x10 -> rdata=0xDEADBEEF, fault=0.
//  2. W=0: read @0x0 -> stall high for 1 cycle; done/rdata valid in cycle 1.
//  3. Read @0x13 (misaligned) -> fault=1, rdata=0 at done.
//     A following read of idx 4 returns its old value.
//  4. mem_read=mem_write=1 @0x20 -> fault=1 with done; RAM[8] unchanged.
//  5. DEPTH=256: write 0x1234 @0x400 -> read @0x0 returns 0x1234 (alias).
//  6. Assert rst in BUSY of a write of 0x55 @0x8 -> all outputs 0, state IDLE.
//     A later read @0x8 returns the prior contents.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Purpose : Shared definitions for the CPU pipeline blocks. These are the data
//           word width, the responder FSM state encodings and the memory
//           operation encodings latched at request acceptance.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_W = 32;

    // FSM state encodings, kept as plain constants so older tools can read them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        MEM_OP_NONE = 2'd0,
        MEM_OP_RD   = 2'd1,
        MEM_OP_WR   = 2'd2
    } mem_op_e;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Purpose : Single-port synchronous word RAM with a registered read port.
//           Storage has no reset, so contents survive a pipeline reset.
// Ports   : clk    - rising-edge clock
//           we     - write enable, writes wdata to mem[idx] on the clock edge
//           idx    - word index
//           wdata  - write data
//           rdata  - registered read of mem[idx] (value before any write at
//                    the same edge)
// -----------------------------------------------------------------------------
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Read-first behaviour: rdata captures the old contents on a write edge.
    // The responder never uses read data from a write access.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_stage_dmem_responder.sv
// -----------------------------------------------------------------------------
// mem_stage_dmem_responder
// Purpose : Services MEM-stage load/store requests against a word-addressed
//           RAM. Each access is stretched by WAIT_STATES busy cycles, and the
//           pipeline is stalled until the access completes.
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-high reset
//           mem_read   - load request
//           mem_write  - store request
//           addr       - byte address; bits [IDX_W+1:2] select the word
//           wdata      - store data
//           rdata      - load data, non-zero only during a good read's done
//           done       - one-cycle completion pulse
//           stall      - freeze the upstream pipeline registers
//           fault      - misaligned or read+write request, pulses with done
// -----------------------------------------------------------------------------
module mem_stage_dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              done,
    output logic              stall,
    output logic              fault
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    mem_op_e           op_q, op_d;
    logic              fault_q, fault_d;

    logic              req;
    logic              accept;
    logic              enter_done;
    logic              req_fault;
    mem_op_e           req_op;
    logic [IDX_W-1:0]  acc_idx;
    logic [WORD_W-1:0] acc_wdata;
    mem_op_e           acc_op;
    logic              acc_fault;
    logic              ram_we;
    logic [WORD_W-1:0] ram_rdata;
    logic              unused_addr;

    // Upper address bits alias onto the RAM, so they are deliberately ignored
    assign unused_addr = ^addr[WORD_W-1:IDX_W+2];

    assign req       = mem_read | mem_write;
    assign accept    = (state_q == ST_IDLE) & req;
    assign req_fault = (addr[1:0] != 2'b00) | (mem_read & mem_write);
    assign req_op    = mem_write ? MEM_OP_WR : (mem_read ? MEM_OP_RD : MEM_OP_NONE);

    // With no wait states the commit edge is the acceptance edge itself, so
    // the RAM must see the live request instead of the not-yet-latched copy.
    assign enter_done = (accept & (WAIT_STATES == 0)) |
                        ((state_q == ST_BUSY) & (cnt_q == 4'd0));
    assign acc_idx    = accept ? addr[IDX_W+1:2] : idx_q;
    assign acc_wdata  = accept ? wdata : wdata_q;
    assign acc_op     = accept ? req_op : op_q;
    assign acc_fault  = accept ? req_fault : fault_q;
    assign ram_we     = enter_done & (acc_op == MEM_OP_WR) & ~acc_fault;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Request latch, wait counter and state sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = addr[IDX_W+1:2];
                    wdata_d = wdata;
                    op_d    = req_op;
                    fault_d = req_fault;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES == 0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= MEM_OP_NONE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            fault_q <= fault_d;
        end
    end

    assign stall = accept | (state_q == ST_BUSY);
    assign done  = (state_q == ST_DONE);
    assign fault = done & fault_q;
    assign rdata = (done & ~fault_q & (op_q == MEM_OP_RD)) ? ram_rdata : '0;

endmodule
